// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, parity modes, baud divisor helper.
package uart_pkg;

  // Receiver/transmitter state encoding
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = S_IDLE,
    START  = S_START,
    DATA   = S_DATA,
    PARITY = S_PARITY,
    STOP   = S_STOP
  } uart_state_e;

  // Parity modes
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Clocks per oversample tick, rounded to nearest
  function automatic int uart_div(input longint clk_freq, input longint baud,
                                  input longint os);
    longint den;
    den = baud * os;
    return int'((clk_freq + den / 2) / den);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle tick every DIV clocks, synchronously
// restartable so tick phase can be aligned to an external event.
module uart_baud_tick #(
  parameter int DIV = 651
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // Free-running divider, held at zero while restart is asserted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       cnt <= '0;
    else if (restart || cnt == LAST)  cnt <= '0;
    else                              cnt <= cnt + 1'b1;
  end

  assign tick = !restart && (cnt == LAST);

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable oversampling UART receiver with 2-of-3 majority sampling,
// false-start rejection, parity/framing/overrun reporting and a one-entry
// valid/ready holding register.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_perr,
  output logic                 rx_ferr,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_overrun,
  output logic                 rx_busy
);

  localparam int   DIV = uart_div(longint'(CLK_FREQ), longint'(BAUD), longint'(OVERSAMPLE));
  localparam int   M   = OVERSAMPLE / 2;
  localparam int   TW  = $clog2(OVERSAMPLE);
  localparam int   BW  = $clog2(DATA_BITS);
  localparam logic POL = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;

  uart_state_e state, state_nx;

  logic                 rx_m, rx_s, rx_d;
  logic                 tick, tick_mid, tick_end, maj, fall;
  logic [TW-1:0]        tcnt;       // ticks already elapsed in the current bit
  logic [BW-1:0]        bit_cnt;
  logic                 stop_cnt;
  logic                 last_stop;
  logic                 s0, s1;     // samples at ticks M-1 and M
  logic [DATA_BITS-1:0] shreg;
  logic                 perr_r, ferr_acc;
  logic                 frame_done, load;

  // Two-flop synchroniser plus one delay flop for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      rx_d <= rx_s;
    end
  end

  assign fall = rx_d & ~rx_s;

  // Divider held in IDLE so the first tick lands DIV clocks after the start edge
  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (state == IDLE),
    .tick    (tick)
  );

  // Tick M+1 is the third sample; tick OVERSAMPLE closes the bit
  assign tick_mid  = tick && (tcnt == TW'(M));
  assign tick_end  = tick && (tcnt == TW'(OVERSAMPLE - 1));
  assign maj       = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
  assign last_stop = (STOP_BITS == 1) ? 1'b1 : stop_cnt;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic; completion fires at mid-sample of the last stop bit
  always_comb begin
    state_nx   = state;
    frame_done = 1'b0;
    case (state)
      IDLE:   if (fall) state_nx = START;
      START: begin
        if (tick_mid && maj) state_nx = IDLE;
        else if (tick_end)   state_nx = DATA;
      end
      DATA:   if (tick_end && bit_cnt == BW'(DATA_BITS - 1))
                state_nx = (PARITY_EN != 0) ? PARITY : STOP;
      PARITY: if (tick_end) state_nx = STOP;
      STOP:   if (tick_mid && last_stop) begin
                state_nx   = IDLE;
                frame_done = 1'b1;
              end
      default: state_nx = IDLE;
    endcase
  end

  // Bit timing, sampling and frame accumulation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt     <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      s0       <= 1'b1;
      s1       <= 1'b1;
      shreg    <= '0;
      perr_r   <= 1'b0;
      ferr_acc <= 1'b0;
    end else if (state == IDLE) begin
      tcnt     <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      perr_r   <= 1'b0;
      ferr_acc <= 1'b0;
    end else if (tick) begin
      tcnt <= tick_end ? '0 : tcnt + 1'b1;
      if (tcnt == TW'(M - 2)) s0 <= rx_s;
      if (tcnt == TW'(M - 1)) s1 <= rx_s;
      if (tick_mid) begin
        case (state)
          DATA:    shreg    <= {maj, shreg[DATA_BITS-1:1]};
          PARITY:  perr_r   <= maj ^ (^shreg) ^ POL;
          STOP:    ferr_acc <= ferr_acc | ~maj;
          default: ;
        endcase
      end
      if (tick_end) begin
        if (state == DATA) bit_cnt  <= bit_cnt + 1'b1;
        if (state == STOP) stop_cnt <= 1'b1;
      end
    end
  end

  // Load into an empty register, or one being drained this same cycle
  assign load = frame_done && (!rx_valid || rx_ready);

  // Holding register, valid/ready handshake and overrun pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data    <= '0;
      rx_perr    <= 1'b0;
      rx_ferr    <= 1'b0;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      rx_overrun <= frame_done && rx_valid && !rx_ready;
      if (load) begin
        rx_data  <= shreg;
        rx_perr  <= perr_r;
        rx_ferr  <= ferr_acc | ~maj;
        rx_valid <= 1'b1;
      end else if (rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

  assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: three configurations (8N1, 8E2, 5O1), directed
// scenarios on the first two, then randomized frames on all three against a
// frame-level reference model and expected-word queues.
module tb_uart_rx_cfg;

  localparam int CLK_FREQ = 1_280_000;
  localparam int BAUD     = 10_000;
  localparam int OS [3] = '{16, 16, 8};
  localparam int NB [3] = '{8, 8, 5};
  localparam int PE [3] = '{0, 1, 1};
  localparam int PO [3] = '{0, 0, 1};
  localparam int NS [3] = '{1, 2, 1};
  localparam int BIT = CLK_FREQ / BAUD;    // 128 clocks per bit
  localparam int DIV0 = BIT / 16;          // clocks per tick for instance 0

  typedef struct {
    logic [8:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] rx, rdy;
  wire  [2:0] vld, perr, ferr, ovr, busy;
  wire  [7:0] d0, d1;
  wire  [4:0] d2;

  exp_t q0[$], q1[$], q2[$];
  int   n_chk = 0, n_fail = 0, cyc = 0;
  int   t_sb [3], t_rise [3], ovr_cnt [3];
  logic [2:0] hs_prev = '0, vld_prev = '0;
  bit   rand_done;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_cfg #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(OS[0]), .DATA_BITS(NB[0]),
    .PARITY_EN(PE[0]), .PARITY_ODD(PO[0]), .STOP_BITS(NS[0])) u_dut0 (
    .clk(clk), .rst_n(rst_n), .rx(rx[0]), .rx_data(d0), .rx_perr(perr[0]),
    .rx_ferr(ferr[0]), .rx_valid(vld[0]), .rx_ready(rdy[0]), .rx_overrun(ovr[0]),
    .rx_busy(busy[0]));

  uart_rx_cfg #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(OS[1]), .DATA_BITS(NB[1]),
    .PARITY_EN(PE[1]), .PARITY_ODD(PO[1]), .STOP_BITS(NS[1])) u_dut1 (
    .clk(clk), .rst_n(rst_n), .rx(rx[1]), .rx_data(d1), .rx_perr(perr[1]),
    .rx_ferr(ferr[1]), .rx_valid(vld[1]), .rx_ready(rdy[1]), .rx_overrun(ovr[1]),
    .rx_busy(busy[1]));

  uart_rx_cfg #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(OS[2]), .DATA_BITS(NB[2]),
    .PARITY_EN(PE[2]), .PARITY_ODD(PO[2]), .STOP_BITS(NS[2])) u_dut2 (
    .clk(clk), .rst_n(rst_n), .rx(rx[2]), .rx_data(d2), .rx_perr(perr[2]),
    .rx_ferr(ferr[2]), .rx_valid(vld[2]), .rx_ready(rdy[2]), .rx_overrun(ovr[2]),
    .rx_busy(busy[2]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [8:0] get_dat(input int i);
    case (i)
      0:       return {1'b0, d0};
      1:       return {1'b0, d1};
      default: return {4'b0, d2};
    endcase
  endfunction

  // Frame-level reference: what a correct receiver must report for this frame
  function automatic exp_t model(input int idx, input logic [8:0] d, input logic pbit,
                                 input logic [1:0] st);
    exp_t e;
    e.d  = d;
    e.pe = (PE[idx] != 0) && (pbit != ((^d) ^ (PO[idx] != 0)));
    e.fe = !st[0] || (NS[idx] == 2 && !st[1]);
    return e;
  endfunction

  function automatic logic [8:0] mask(input int idx, input logic [8:0] d);
    logic [8:0] m;
    m = 9'((1 << NB[idx]) - 1);
    return d & m;
  endfunction

  task automatic push(input int idx, input exp_t e);
    case (idx)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  // Drive one frame on rx[idx]; caller decides whether a word is expected
  task automatic send_frame(input int idx, input logic [8:0] d, input logic pbit,
                            input logic [1:0] st);
    t_sb[idx] = cyc;
    rx[idx] = 1'b0;
    step(BIT);
    for (int b = 0; b < NB[idx]; b++) begin
      rx[idx] = d[b];
      step(BIT);
    end
    if (PE[idx] != 0) begin
      rx[idx] = pbit;
      step(BIT);
    end
    for (int s = 0; s < NS[idx]; s++) begin
      rx[idx] = st[s];
      step(BIT);
    end
    rx[idx] = 1'b1;
  endtask

  task automatic frame(input int idx, input logic [8:0] d, input logic pbit,
                       input logic [1:0] st);
    push(idx, model(idx, mask(idx, d), pbit, st));
    send_frame(idx, mask(idx, d), pbit, st);
  endtask

  task automatic pop_check(input int i);
    exp_t e;
    bit   ok;
    ok = 1'b0;
    case (i)
      0:       if (q0.size() != 0) begin e = q0.pop_front(); ok = 1'b1; end
      1:       if (q1.size() != 0) begin e = q1.pop_front(); ok = 1'b1; end
      default: if (q2.size() != 0) begin e = q2.pop_front(); ok = 1'b1; end
    endcase
    chk($sformatf("u%0d_beat_expected", i), 32'(ok), 1);
    if (ok) begin
      chk($sformatf("u%0d_data", i), 32'(get_dat(i)), 32'(e.d));
      chk($sformatf("u%0d_perr", i), 32'(perr[i]), 32'(e.pe));
      chk($sformatf("u%0d_ferr", i), 32'(ferr[i]), 32'(e.fe));
    end
  endtask

  // Consumer side: score every handshake, track overrun pulses and valid rise
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (hs_prev[i]) chk($sformatf("u%0d_valid_clear", i), 32'(vld[i]), 0);
      if (vld[i] && !vld_prev[i]) t_rise[i] = cyc;
      if (ovr[i]) ovr_cnt[i]++;
      if (vld[i] && rdy[i]) pop_check(i);
    end
    hs_prev  = vld & rdy;
    vld_prev = vld;
  end

  task automatic run_random(input int idx);
    logic [8:0] d;
    logic       pb;
    logic [1:0] st;
    int         gap;
    repeat (8) begin
      d     = 9'($urandom);
      pb    = 1'($urandom_range(0, 1));
      st[0] = ($urandom_range(0, 4) != 0);
      st[1] = (NS[idx] == 1) ? 1'b1 : ($urandom_range(0, 4) != 0);
      frame(idx, d, pb, st);
      if (!st[NS[idx]-1]) gap = 1 + int'($urandom_range(0, 1));
      else                gap = int'($urandom_range(0, 2));
      step(gap * BIT + 1);
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      t_sb[i] = 0; t_rise[i] = 0; ovr_cnt[i] = 0;
    end
    rst_n = 1'b0;
    rx    = 3'b111;
    rdy   = 3'b111;
    step(5);
    chk("rst_valid", 32'(vld), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_overrun", 32'(ovr), 0);
    chk("rst_flags", 32'({perr, ferr}), 0);
    chk("rst_data0", 32'(d0), 0);
    rst_n = 1'b1;
    step(2 * BIT);

    // 8N1 basic words, with latency of the first
    frame(0, 9'h55, 1'b0, 2'b11);
    chk("lat_8n1_window",
        32'(((t_rise[0] - t_sb[0]) >= 9 * BIT + 8 * DIV0) &&
            ((t_rise[0] - t_sb[0]) <= 9 * BIT + 9 * DIV0 + 4)), 1);
    frame(0, 9'hA3, 1'b0, 2'b11);
    step(BIT);

    // Framing error delivered with flag, then normal reception
    frame(0, 9'h3C, 1'b0, 2'b10);
    step(2 * BIT);
    frame(0, 9'hC3, 1'b0, 2'b11);
    step(BIT);

    // Short low glitch must be rejected as a false start
    rx[0] = 1'b0;
    step(BIT / 4);
    rx[0] = 1'b1;
    step(20 - BIT / 4);
    chk("glitch_busy_mid", 32'(busy[0]), 1);
    step(80);
    chk("glitch_busy_end", 32'(busy[0]), 0);
    chk("glitch_no_valid", 32'(vld[0]), 0);
    step(BIT);
    frame(0, 9'h81, 1'b0, 2'b11);
    step(BIT);

    // Overrun: second word dropped, held word unchanged
    rdy[0] = 1'b0;
    frame(0, 9'h11, 1'b0, 2'b11);
    send_frame(0, 9'h22, 1'b0, 2'b11);
    step(BIT);
    chk("ovr_hold_valid", 32'(vld[0]), 1);
    chk("ovr_hold_data", 32'(d0), 32'h11);
    chk("ovr_pulse_cycles", 32'(ovr_cnt[0]), 1);
    rdy[0] = 1'b1;
    step(10);
    chk("ovr_drained", 32'(q0.size()), 0);

    // Reset mid-frame with a word held
    rdy[0] = 1'b0;
    send_frame(0, 9'h5A, 1'b0, 2'b11);
    step(BIT);
    chk("pre_rst_valid", 32'(vld[0]), 1);
    rx[0] = 1'b0;
    step(4 * BIT + BIT / 2);
    chk("pre_rst_busy", 32'(busy[0]), 1);
    rst_n = 1'b0;
    rx[0] = 1'b1;
    step(10);
    chk("mid_rst_data", 32'(d0), 0);
    chk("mid_rst_flags", 32'({perr[0], ferr[0], ovr[0]}), 0);
    chk("mid_rst_valid", 32'(vld[0]), 0);
    chk("mid_rst_busy", 32'(busy[0]), 0);
    rdy[0] = 1'b1;
    rst_n  = 1'b1;
    step(2 * BIT);
    frame(0, 9'h7E, 1'b0, 2'b11);
    step(BIT);

    // 8E2: parity correct/incorrect, each stop bit failing on its own
    frame(1, 9'hA3, 1'b0, 2'b11);
    frame(1, 9'hA3, 1'b1, 2'b11);
    step(BIT);
    frame(1, 9'h96, 1'b0, 2'b01);
    step(2 * BIT);
    frame(1, 9'h0F, 1'b0, 2'b10);
    step(2 * BIT);

    // Randomized frames on all three configurations in parallel
    rand_done = 1'b0;
    fork
      begin
        while (!rand_done) begin
          step(1);
          rdy = 3'($urandom) | 3'($urandom);
        end
      end
      begin
        fork
          run_random(0);
          run_random(1);
          run_random(2);
        join
        rand_done = 1'b1;
      end
    join
    rdy = 3'b111;
    step(2 * BIT);

    chk("end_q0_empty", 32'(q0.size()), 0);
    chk("end_q1_empty", 32'(q1.size()), 0);
    chk("end_q2_empty", 32'(q2.size()), 0);
    chk("end_ovr0", 32'(ovr_cnt[0]), 1);
    chk("end_ovr1", 32'(ovr_cnt[1]), 0);
    chk("end_ovr2", 32'(ovr_cnt[2]), 0);
    chk("end_idle", 32'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
